fir3_core: RTL and testbench



---
 rtl/fir_pkg.sv | 19 +
 rtl/fir3_core_if.sv | 27 ++
 rtl/fir3_core_braun.sv | 22 ++
 rtl/fir3_core.sv | 109 ++++++++++
 tb/tb_fir3_core.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the 3-tap FIR filter.
package fir_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 18;
  localparam int TAPS   = 3;

  localparam logic [DATA_W-1:0] COEF0_DEF = 8'd1;
  localparam logic [DATA_W-1:0] COEF1_DEF = 8'd2;
  localparam logic [DATA_W-1:0] COEF2_DEF = 8'd1;

  typedef enum logic [1:0] {
    C0 = 2'd0,
    C1 = 2'd1,
    C2 = 2'd2
  } coef_sel_e;

endpackage

// File: rtl/fir3_core_if.sv
// Sample, coefficient and result handshakes of fir3_core grouped in one bundle.
interface fir3_core_if;
  import fir_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              clr;
  logic              coef_we;
  logic [1:0]        coef_sel;
  logic [DATA_W-1:0] coef_data;
  logic              coef_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, clr, coef_we, coef_sel, coef_data, out_ready,
    input  in_ready, coef_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, clr, coef_we, coef_sel, coef_data, out_ready,
    output in_ready, coef_ready, out_valid, out_data
  );

endinterface

// File: rtl/fir3_core_braun.sv
// 8x8 unsigned array multiplier: one shifted partial-product row added per multiplier bit.
module Braun_Multiplier (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_row
    logic [15:0] w_pp;
    logic [15:0] w_acc;
    assign w_pp = {8'b0, i_a & {8{i_b[gi]}}} << gi;
    if (gi == 0) begin : g_first
      assign w_acc = w_pp;
    end else begin : g_next
      assign w_acc = g_row[gi-1].w_acc + w_pp;
    end
  end

  assign o_p = g_row[7].w_acc;

endmodule

// File: rtl/fir3_core.sv
// 3-tap FIR: delay line and coefficients feed three multipliers, products registered,
// then summed into an 18-bit result. The whole pipeline stalls on output backpressure.
module fir3_core
  import fir_pkg::*;
#(
  parameter logic [DATA_W-1:0] COEF0 = COEF0_DEF,
  parameter logic [DATA_W-1:0] COEF1 = COEF1_DEF,
  parameter logic [DATA_W-1:0] COEF2 = COEF2_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  fir3_core_if.slave   bus
);

  logic              w_en;
  logic              w_accept;
  logic              w_coef_ready;
  logic              w_coef_wr;
  logic [ACC_W-1:0]  w_sum;
  logic [PROD_W-1:0] w_prod [TAPS];

  logic [DATA_W-1:0] r_x    [TAPS];
  logic [DATA_W-1:0] r_coef [TAPS];
  logic [PROD_W-1:0] r_p    [TAPS];
  logic              r_v0;
  logic              r_v1;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_data;

  assign w_en         = ~r_out_valid | bus.out_ready;
  assign bus.in_ready = w_en & ~bus.clr & rst_n;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_coef_ready = ~(r_v0 | r_v1 | r_out_valid);
  assign w_coef_wr    = bus.coef_we & w_coef_ready;

  assign bus.coef_ready = w_coef_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;

  genvar gi;
  for (gi = 0; gi < TAPS; gi++) begin : g_mult
    Braun_Multiplier u_mult (
      .i_a (r_x[gi]),
      .i_b (r_coef[gi]),
      .o_p (w_prod[gi])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_sum = w_sum + ACC_W'(r_p[i]);
    end
  end

  // Select value 3 falls to the default arm and leaves every coefficient untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef[0] <= COEF0;
      r_coef[1] <= COEF1;
      r_coef[2] <= COEF2;
    end else if (w_coef_wr) begin
      case (coef_sel_e'(bus.coef_sel))
        C0:      r_coef[0] <= bus.coef_data;
        C1:      r_coef[1] <= bus.coef_data;
        C2:      r_coef[2] <= bus.coef_data;
        default: ;
      endcase
    end
  end

  // clr overrides the stall so a flush always takes effect at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
        r_p[i] <= '0;
      end
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
      end
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      if (w_accept) begin
        r_x[0] <= bus.in_data;
        for (int i = 1; i < TAPS; i++) begin
          r_x[i] <= r_x[i-1];
        end
      end
      for (int i = 0; i < TAPS; i++) begin
        r_p[i] <= w_prod[i];
      end
      r_v0        <= w_accept;
      r_v1        <= r_v0;
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_out_data <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_fir3_core.sv
// Scoreboard bench for fir3_core: driver pushes reference results, a monitor pops on output transfers.
module tb_fir3_core;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fir3_core_if bus ();

  fir3_core #(.COEF0(8'd1), .COEF1(8'd2), .COEF2(8'd1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int stamp_q[$];
  int cyc_cnt = 0;
  bit check_lat = 1'b0;
  int last_data = 0;
  bit last_acc = 1'b0;
  int m_coef[3];
  int m_hist[2];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_coef = '{1, 2, 1};
    m_hist = '{0, 0};
    exp_q.delete();
    stamp_q.delete();
  endtask

  // Reference: y = c0*x[n] + c1*x[n-1] + c2*x[n-2]; coefficient writes count only with nothing in flight.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy,
                     input logic we, input logic [1:0] sel, input logic [7:0] cd,
                     input logic cl);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.coef_we   = we;
    bus.coef_sel  = sel;
    bus.coef_data = cd;
    bus.clr       = cl;
    #3;
    last_acc = 1'b0;
    if (rst_n) begin
      chk("coef_ready", int'(bus.coef_ready), int'(exp_q.size() == 0));
      if (cl) chk("clr_in_ready", int'(bus.in_ready), 0);
      last_acc = v && bus.in_ready;
      if (we && exp_q.size() == 0 && sel != 2'd3) m_coef[sel] = int'(cd);
      if (cl) begin
        exp_q.delete();
        stamp_q.delete();
        m_hist = '{0, 0};
      end else if (last_acc) begin
        exp_q.push_back(m_coef[0] * int'(d) + m_coef[1] * m_hist[0] + m_coef[2] * m_hist[1]);
        stamp_q.push_back(cyc_cnt + 1);
        m_hist[1] = m_hist[0];
        m_hist[0] = int'(d);
      end
    end
  endtask

  task automatic send(input logic [7:0] d);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, d, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
      if (last_acc) break;
    end
    chk("send_accepted", int'(last_acc), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      cyc(1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares every transferred result and checks that stalls hold the output.
  bit stall_prev = 1'b0;
  int held = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && bus.out_valid) chk("stall_hold", int'(bus.out_data), held);
        if (bus.out_valid && !bus.out_ready) begin
          chk("stall_in_ready", int'(bus.in_ready), 0);
          held = int'(bus.out_data);
          stall_prev = 1'b1;
        end else begin
          stall_prev = 1'b0;
        end
        if (bus.out_valid && bus.out_ready && !bus.clr) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(bus.out_valid), 0);
          end else begin
            chk("out_data", int'(bus.out_data), exp_q.pop_front());
            if (check_lat) chk("latency", cyc_cnt - stamp_q[0], 2);
            void'(stamp_q.pop_front());
            last_data = int'(bus.out_data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int k;
    bus.in_valid = 0; bus.in_data = 0; bus.clr = 0; bus.coef_we = 0;
    bus.coef_sel = 0; bus.coef_data = 0; bus.out_ready = 1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_coef_ready", int'(bus.coef_ready), 1);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #3 chk("release_in_ready", int'(bus.in_ready), 1);

    // Default coefficients, back-to-back 10,20,30.
    check_lat = 1'b1;
    send(8'd10); send(8'd20); send(8'd30);
    drain();
    check_lat = 1'b0;
    chk("basic_last", last_data, 80);

    // All coefficients 255, largest result.
    cyc(0, 0, 1, 1, 2'd0, 8'd255, 0);
    cyc(0, 0, 1, 1, 2'd1, 8'd255, 0);
    cyc(0, 0, 1, 1, 2'd2, 8'd255, 0);
    send(8'd255); send(8'd255); send(8'd255);
    drain();
    chk("max_result", last_data, 195075);

    // Stream 1..6 with a 3-cycle consumer stall.
    idx = 1; k = 0;
    while (idx <= 6 && k < 40) begin
      cyc(1, 8'(idx), !(k >= 3 && k < 6), 0, 2'd0, 8'd0, 0);
      if (last_acc) idx++;
      k++;
    end
    chk("stall_stream_sent", idx, 7);
    drain();

    // Coefficient write while busy is dropped; after drain it lands.
    send(8'd3);
    cyc(0, 0, 1, 1, 2'd1, 8'd5, 0);
    drain();
    cyc(0, 0, 1, 1, 2'd1, 8'd5, 0);
    cyc(0, 0, 1, 0, 2'd0, 8'd0, 1);
    send(8'd1); send(8'd0);
    drain();
    chk("c1_applied", last_data, 5);

    // Flush with two samples in flight.
    send(8'd11); send(8'd12);
    cyc(0, 0, 1, 0, 2'd0, 8'd0, 1);
    cyc(0, 0, 1, 0, 2'd0, 8'd0, 0);
    chk("clr_flush", int'(bus.out_valid), 0);
    send(8'd7);
    drain();
    chk("after_clr", last_data, 1785);

    // Asynchronous reset mid-stream.
    send(8'd5); send(8'd6);
    bus.in_valid = 0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_data", int'(bus.out_data), 0);
    chk("midrst_coef_ready", int'(bus.coef_ready), 1);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'd4);
    drain();
    chk("post_reset", last_data, 4);

    // Randomized traffic with occasional idle gaps, coefficient writes and flushes.
    for (int i = 0; i < 400; i++) begin
      cyc((i % 50) < 38 && ($urandom % 4 != 0), 8'($urandom), ($urandom % 4) != 0,
          ($urandom % 6) == 0, 2'($urandom), 8'($urandom), ($urandom % 40) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
